shift_ctrl: RTL and testbench
=============================

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter: N, default 16, shift register width (number of shift pulses per operation).
REQ-002 Parameter: CW, default 5, count width; SHALL satisfy 2**CW > N.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request one load-and-shift operation; sampled only in IDLE.
REQ-006 cnt_len  input  CW  shift count; present only when SHIFT_CTRL_PROG_EN is defined.
REQ-007 ld  output  1  parallel-load strobe to the shift register.
REQ-008 shen  output  1  shift-enable to the shift register.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 bit_cnt  output  CW  shift pulses issued in the current or last operation.

Function
REQ-012 FSM states: IDLE, LOAD, SHIFT, DONE; all outputs are registered or decoded from the state register only, with no combinational path from start.
REQ-013 IDLE: ld=0, shen=0, busy=0, done=0; start=1 at an edge -> LOAD.
REQ-014 LOAD: ld=1 for exactly one cycle; bit_cnt cleared to 0; len>0 -> SHIFT; len=0 -> DONE.
REQ-015 SHIFT: shen=1 every cycle; bit_cnt increments by 1 per cycle; bit_cnt reaching len -> DONE.
REQ-016 DONE: done=1 for exactly one cycle, busy=1; -> IDLE unconditionally.
REQ-017 Latency: start accepted at edge t -> ld high in cycle t+1, shen high in cycles t+2 .. t+1+len, done high in cycle t+2+len.
REQ-018 ld and shen SHALL never be high in the same cycle.
REQ-019 start while busy=1 (including DONE) is ignored, not queued.
REQ-020 start held high continuously -> back-to-back operations; each new LOAD follows one IDLE cycle after DONE.
REQ-021 bit_cnt holds its final value in DONE and IDLE until the next LOAD.
REQ-022 bit_cnt arithmetic is unsigned CW-bit and SHALL never exceed len.

Reset
REQ-023 clr=1 forces IDLE immediately, asynchronously: ld=0, shen=0, busy=0, done=0, bit_cnt=0.
REQ-024 clr asserted mid-operation (LOAD/SHIFT/DONE) aborts it; no done pulse is generated for the aborted operation.
REQ-025 After clr deasserts, the first start is accepted at the first rising edge with start=1.

Configuration
REQ-026 Macro SHIFT_CTRL_PROG_EN defined: cnt_len port exists; len = cnt_len captured at start acceptance and held constant for the whole operation.
REQ-027 With the macro: cnt_len > N clamps to N; cnt_len = 0 gives LOAD -> DONE with no shen.
REQ-028 Macro undefined: no cnt_len port; len fixed at N.

Structure
REQ-029 Package shift_ctrl_pkg holds the state encoding constants (IDLE=2'b00, LOAD=2'b01, SHIFT=2'b10, DONE=2'b11) and default N/CW.
REQ-030 One sub-module, shift_cnt: a CW-bit up-counter with synchronous clear, enable, and asynchronous active-high clr, driving bit_cnt.

Verification
REQ-031 clr pulse mid-SHIFT at bit_cnt=7 -> all outputs 0 next sample, no done; next start runs a full 16 shifts.
REQ-032 Macro off, N=16, single start pulse -> ld 1 cycle, shen 16 consecutive cycles, done at t+18, bit_cnt=16.
REQ-033 start held high for 60 cycles -> operations separated by exactly one IDLE cycle; ld/shen never overlap.
REQ-034 start pulsed during SHIFT and DONE -> ignored; shen count remains 16 per operation.
REQ-035 Macro on, cnt_len=5 -> 5 shen cycles, done at t+7; cnt_len changed mid-operation has no effect.
REQ-036 Macro on, cnt_len=0 -> ld then done next cycle, no shen; cnt_len=31 -> clamped to 16 shifts.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared state encoding and default sizing for the shift_ctrl load-and-shift sequencer.
package shift_ctrl_pkg;
  localparam int N_DEF  = 16;
  localparam int CW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } state_t;
endpackage

// File: rtl/shift_cnt.sv
// CW-bit shift-pulse counter: async clear, synchronous clear, count enable.
module shift_cnt #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sclr,
  input  logic          en,
  output logic [CW-1:0] cnt
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       cnt <= '0;
    else if (sclr) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/shift_ctrl.sv
// Load-then-shift sequencer for an N-bit shift register.
// Define SHIFT_CTRL_PROG_EN to add the cnt_len port (per-operation shift count, clamped to N).
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
`ifdef SHIFT_CTRL_PROG_EN
  input  logic [CW-1:0] cnt_len,
`endif
  output logic          ld,
  output logic          shen,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] bit_cnt
);
  state_t        state, nxt;
  logic [CW-1:0] len;
  logic          accept;

  assign accept = (state == IDLE) && start;

`ifdef SHIFT_CTRL_PROG_EN
  // Length is frozen at acceptance so cnt_len may change freely mid-operation.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)         len <= CW'(N);
    else if (accept) len <= (cnt_len > CW'(N)) ? CW'(N) : cnt_len;
  end
`else
  assign len = CW'(N);
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    ld   = 1'b0;
    shen = 1'b0;
    busy = 1'b1;
    done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = LOAD;
      end
      LOAD: begin
        ld  = 1'b1;
        nxt = (len == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        shen = 1'b1;
        // Counter is about to reach len on this edge.
        if (bit_cnt + CW'(1) == len) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
    endcase
  end

  // Cleared on the edge entering LOAD, so bit_cnt reads 0 during LOAD.
  shift_cnt #(.CW(CW)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .sclr (accept),
    .en   (state == SHIFT),
    .cnt  (bit_cnt)
  );
endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized bench for shift_ctrl against a cycle-offset schedule model; works with or without SHIFT_CTRL_PROG_EN.
module tb_shift_ctrl;
  localparam int N  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [CW-1:0] cnt_len;
  logic          ld, shen, busy, done;
  logic [CW-1:0] bit_cnt;

  int checks = 0;
  int failures = 0;

  // Model: an operation accepted at edge t occupies offsets k=1 (load),
  // k=2..1+len (shift), k=2+len (done), where k = edge index - t + 1.
  int cyc = 0;
  int t = 0;
  int mlen = 0;
  bit act = 0;
  int cl_val = -1;
  int shen_run = 0;

  always #5 clk = ~clk;

  shift_ctrl #(.N(N), .CW(CW)) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
`ifdef SHIFT_CTRL_PROG_EN
    .cnt_len (cnt_len),
`endif
    .ld      (ld),
    .shen    (shen),
    .busy    (busy),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int exp_len();
`ifdef SHIFT_CTRL_PROG_EN
    return (int'(cnt_len) > N) ? N : int'(cnt_len);
`else
    return N;
`endif
  endfunction

  function automatic bit cur_act();
    int k;
    k = cyc - t + 1;
    return act && k >= 1 && k <= 2 + mlen;
  endfunction

  task automatic compare();
    int k;
    bit a;
    int bc;
    k  = cyc - t + 1;
    a  = cur_act();
    bc = !act ? 0 : (k <= 1 ? 0 : ((k - 2 > mlen) ? mlen : k - 2));
    chk("ld",      ld,      int'(a && k == 1));
    chk("shen",    shen,    int'(a && k >= 2 && k <= 1 + mlen));
    chk("done",    done,    int'(a && k == 2 + mlen));
    chk("busy",    busy,    int'(a));
    chk("bit_cnt", bit_cnt, bc);
    chk("ld_shen_excl", int'(ld && shen), 0);
    if (ld) shen_run = 0;
    if (shen) shen_run++;
    if (done) chk("shen_run", shen_run, mlen);
  endtask

  task automatic step(input logic s);
    bit was;
    start   = s;
    cnt_len = (cl_val < 0) ? CW'($urandom_range(0, 31)) : CW'(cl_val);
    was     = cur_act();
    @(posedge clk);
    cyc++;
    if (s && !was) begin
      act  = 1;
      t    = cyc;
      mlen = exp_len();
    end
    @(negedge clk);
    compare();
  endtask

  task automatic clr_pulse();
    #2 clr = 1'b1;
    #1;
    chk("clr_ld",      ld,      0);
    chk("clr_shen",    shen,    0);
    chk("clr_busy",    busy,    0);
    chk("clr_done",    done,    0);
    chk("clr_bit_cnt", bit_cnt, 0);
    act = 0;
    #1 clr = 1'b0;
  endtask

  task automatic single(input int l, input int tail);
    cl_val = l;
    step(1'b1);
    cl_val = -1;
    for (int i = 0; i < tail; i++) step(1'b0);
  endtask

  initial begin
    bit found;
    clr = 1'b1;
    start = 1'b0;
    cnt_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ld",      ld,      0);
    chk("rst_shen",    shen,    0);
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_bit_cnt", bit_cnt, 0);
    clr = 1'b0;

    // Single operations: full length, short, zero, over-range.
    single(16, 24);
    single(5, 12);
    single(0, 6);
    single(31, 24);

    // start held high: back-to-back operations.
    for (int i = 0; i < 60; i++) step(1'b1);
    for (int i = 0; i < 24; i++) step(1'b0);

    // start pulses while busy are ignored.
    cl_val = 16;
    step(1'b1);
    for (int i = 0; i < 24; i++) step(i == 5 || i == 17);
    for (int i = 0; i < 6; i++) step(1'b0);

    // Abort mid-shift at bit_cnt 7, then a full operation.
    cl_val = 16;
    step(1'b1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (shen && bit_cnt == 7) found = 1;
      else step(1'b0);
    end
    chk("clr_wait_bc7", int'(found), 1);
    clr_pulse();
    single(16, 24);

    // Random traffic with occasional aborts.
    cl_val = -1;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 49) == 0) clr_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
